// File: rtl/tuner_pwr_detect_phy.sv
// tuner_pwr_detect_phy
// Settle-then-average power detector for the tuner lock loop. After each
// ring-tune step it waits a programmable number of cycles, then averages
// 2^n photodetector samples. It publishes the new average, the previous
// average and a slope flag, together with a one-cycle update strobe.
// Each completed window re-arms the settle delay, so this block sets the pace
// of the DAC-step / settle / measure loop.

module tuner_pwr_detect_phy #(
    parameter int ADC_WIDTH    = 8,
    parameter int MAX_AVG_LOG2 = 4,
    parameter int SETTLE_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [2:0]              i_cfg_avg_log2,
    input  logic [SETTLE_WIDTH-1:0] i_cfg_settle_cycles,
    input  logic                    i_adc_val,
    input  logic [ADC_WIDTH-1:0]    i_adc_data,
    input  logic                    i_pwr_detect_active,
    input  logic                    i_pwr_detect_refresh,
    output logic                    o_pwr_detect_update,
    output logic [ADC_WIDTH-1:0]    o_pwr_detect_pwr,
    output logic [ADC_WIDTH-1:0]    o_pwr_detect_pwr_prev,
    output logic                    o_pwr_detect_rising,
    output logic                    o_pwr_detect_valid,
    output logic                    o_pwr_detect_busy
);

    // The accumulator holds up to 2^MAX_AVG_LOG2 full-scale samples, so it can never wrap.
    localparam int ACC_W = ADC_WIDTH + MAX_AVG_LOG2;
    // The sample counter must be able to represent 2^MAX_AVG_LOG2 itself.
    localparam int CNT_W = MAX_AVG_LOG2 + 1;
    localparam int N_W   = (MAX_AVG_LOG2 < 1) ? 1 : $clog2(MAX_AVG_LOG2 + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } state_t;

    state_t                  state;
    logic [SETTLE_WIDTH-1:0] settle_cnt;
    logic [N_W-1:0]          n_lat;
    logic [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]        samp_cnt;
    // Number of averages since refresh/reset. It saturates at 2, the point at
    // which prev and rising start to carry meaning.
    logic [1:0]              avg_cnt;

    logic                    update;
    logic [ADC_WIDTH-1:0]    pwr;
    logic [ADC_WIDTH-1:0]    pwr_prev;
    logic                    rising;
    logic                    valid;
    logic                    busy;

    logic [N_W-1:0]          n_clamp;
    logic [CNT_W-1:0]        win_len;
    logic                    last_sample;
    logic [ACC_W-1:0]        sum;
    logic [ADC_WIDTH-1:0]    avg_new;

    // Clamp the requested exponent to the largest window the datapath supports.
    always_comb begin
        n_clamp = N_W'(MAX_AVG_LOG2);
        if (int'(i_cfg_avg_log2) <= MAX_AVG_LOG2) begin
            n_clamp = N_W'(i_cfg_avg_log2);
        end
    end

    // Window arithmetic uses the exponent latched at SETTLE entry, so config
    // changes made in the middle of a window have no effect on that window.
    always_comb begin
        win_len     = CNT_W'(1) << n_lat;
        last_sample = (samp_cnt == (win_len - CNT_W'(1)));
        sum         = acc + ACC_W'(i_adc_data);
        avg_new     = ADC_WIDTH'(sum >> n_lat);
    end

    // Measurement FSM and all registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            n_lat      <= '0;
            acc        <= '0;
            samp_cnt   <= '0;
            avg_cnt    <= '0;
            update     <= 1'b0;
            pwr        <= '0;
            pwr_prev   <= '0;
            rising     <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            update <= 1'b0;
            if (i_pwr_detect_refresh) begin
                // Refresh clears all measurement history and holds off re-arming.
                state      <= IDLE;
                busy       <= 1'b0;
                settle_cnt <= '0;
                acc        <= '0;
                samp_cnt   <= '0;
                avg_cnt    <= '0;
                pwr        <= '0;
                pwr_prev   <= '0;
                rising     <= 1'b0;
                valid      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_pwr_detect_active) begin
                            state      <= SETTLE;
                            busy       <= 1'b1;
                            settle_cnt <= i_cfg_settle_cycles;
                            n_lat      <= n_clamp;
                            acc        <= '0;
                            samp_cnt   <= '0;
                        end
                    end
                    SETTLE: begin
                        // Samples are ignored here while the ring settles.
                        if (!i_pwr_detect_active) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (settle_cnt == '0) begin
                            state <= ACCUM;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (!i_pwr_detect_active) begin
                            // Drop the partial window. Published results are held.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (i_adc_val) begin
                            if (last_sample) begin
                                update   <= 1'b1;
                                pwr      <= avg_new;
                                pwr_prev <= pwr;
                                rising   <= (avg_new > pwr);
                                valid    <= (avg_cnt != 2'd0);
                                if (avg_cnt != 2'd2) begin
                                    avg_cnt <= avg_cnt + 2'd1;
                                end
                                // The consumer steps the DAC on update, so re-arm the settle
                                // delay right away, using fresh config.
                                state      <= SETTLE;
                                settle_cnt <= i_cfg_settle_cycles;
                                n_lat      <= n_clamp;
                                acc        <= '0;
                                samp_cnt   <= '0;
                            end else begin
                                acc      <= sum;
                                samp_cnt <= samp_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_pwr_detect_update   = update;
    assign o_pwr_detect_pwr      = pwr;
    assign o_pwr_detect_pwr_prev = pwr_prev;
    assign o_pwr_detect_rising   = rising;
    assign o_pwr_detect_valid    = valid;
    assign o_pwr_detect_busy     = busy;

endmodule
